// File: rtl/tdpram_fifo_ctrl_pkg.sv
// Shared definitions for the TDPRAM stream FIFO controller: legal RAM read
// latencies and the sizing helpers used by the top and the skid buffer.
package tdpram_fifo_ctrl_pkg;

  // Port B read latency without / with the RAM output register.
  localparam int unsigned RD_LAT_NOREG = 1;
  localparam int unsigned RD_LAT_REG   = 2;

  // True when the RAM can actually be configured for this read latency.
  function automatic bit rd_latency_legal(input int unsigned lat);
    return (lat == RD_LAT_NOREG) || (lat == RD_LAT_REG);
  endfunction

  // Occupancy counter width: RAM depth plus in-flight words plus skid slots.
  function automatic int unsigned count_width(input int unsigned addr_width);
    return addr_width + 2;
  endfunction

  // The skid buffer must absorb every word still in the RAM read pipe plus
  // the one being presented when the consumer stalls.
  function automatic int unsigned skid_depth(input int unsigned rd_latency);
    return rd_latency + 1;
  endfunction

endpackage

// File: rtl/fifo_skid_buffer.sv
// Small first-word-fall-through register FIFO. The head word is visible on
// data_o whenever valid_o is high and stays unchanged until it is popped.
module fifo_skid_buffer #(
  parameter  int unsigned DATA_WIDTH = 8,
  parameter  int unsigned DEPTH      = 2,
  localparam int unsigned CNT_W      = $clog2(DEPTH + 1)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  push_i,
  input  logic [DATA_WIDTH-1:0] data_i,
  input  logic                  pop_i,
  output logic [DATA_WIDTH-1:0] data_o,
  output logic                  valid_o,
  output logic [CNT_W-1:0]      count_o
);

  localparam int unsigned IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [DATA_WIDTH-1:0] mem_d [DEPTH];
  logic [IW-1:0]         wr_idx_q, wr_idx_d;
  logic [IW-1:0]         rd_idx_q, rd_idx_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  do_push;
  logic                  do_pop;

  // Circular index advance; DEPTH need not be a power of two.
  function automatic logic [IW-1:0] next_idx(input logic [IW-1:0] idx);
    return (idx == IW'(DEPTH - 1)) ? '0 : idx + 1'b1;
  endfunction

  // Next-state for storage, indices and occupancy.
  always_comb begin
    mem_d    = mem_q;
    wr_idx_d = wr_idx_q;
    rd_idx_d = rd_idx_q;
    do_pop   = pop_i & (cnt_q != '0);
    do_push  = push_i & ((cnt_q != CNT_W'(DEPTH)) | do_pop);
    if (do_push) begin
      mem_d[wr_idx_q] = data_i;
      wr_idx_d        = next_idx(wr_idx_q);
    end
    if (do_pop) begin
      rd_idx_d = next_idx(rd_idx_q);
    end
    cnt_d = cnt_q + CNT_W'(do_push) - CNT_W'(do_pop);
  end

  // State register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mem_q    <= '{default: '0};
      wr_idx_q <= '0;
      rd_idx_q <= '0;
      cnt_q    <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_idx_q <= wr_idx_d;
      rd_idx_q <= rd_idx_d;
      cnt_q    <= cnt_d;
    end
  end

  assign data_o  = mem_q[rd_idx_q];
  assign valid_o = (cnt_q != '0);
  assign count_o = cnt_q;

endmodule

// File: rtl/tdpram_fifo_ctrl.sv
// Ready/valid stream FIFO controller wrapped around a true dual-port RAM.
// Port A writes, port B reads; read latency is hidden by a valid pipe that
// feeds a skid buffer, giving a first-word-fall-through output.
//
// Handshake: a word moves on an interface only at a rising edge where both
// its valid and ready are high. Valid never depends on ready, and a presented
// RD_DATA_O/RD_VALID_O pair holds until it is accepted.
module tdpram_fifo_ctrl
  import tdpram_fifo_ctrl_pkg::*;
#(
  parameter int unsigned DATA_WIDTH     = 8,
  parameter int unsigned ADDR_WIDTH     = 9,
  parameter int unsigned RAM_RD_LATENCY = 1,
  parameter int unsigned AFULL_THRESH   = (1 << ADDR_WIDTH) - 4
) (
  input  logic                    CLK_I,
  input  logic                    NRST_I,
  input  logic [DATA_WIDTH-1:0]   WR_DATA_I,
  input  logic                    WR_VALID_I,
  output logic                    WR_READY_O,
  output logic [DATA_WIDTH-1:0]   RD_DATA_O,
  output logic                    RD_VALID_O,
  input  logic                    RD_READY_I,
  output logic                    RAM_WENA_O,
  output logic [ADDR_WIDTH-1:0]   RAM_ADDRA_O,
  output logic [DATA_WIDTH-1:0]   RAM_DINA_O,
  output logic                    RAM_WENB_O,
  output logic [ADDR_WIDTH-1:0]   RAM_ADDRB_O,
  input  logic [DATA_WIDTH-1:0]   RAM_DOUTB_I,
  output logic [ADDR_WIDTH+1:0]   COUNT_O,
  output logic                    FULL_O,
  output logic                    EMPTY_O,
  output logic                    AFULL_O
);

  localparam int unsigned DEPTH      = 1 << ADDR_WIDTH;
  localparam int unsigned CNT_W      = count_width(ADDR_WIDTH);
  localparam int unsigned RCW        = ADDR_WIDTH + 1;
  localparam int unsigned SKID_DEPTH = skid_depth(RAM_RD_LATENCY);
  localparam int unsigned SKID_CW    = $clog2(SKID_DEPTH + 1);
  localparam int unsigned OCC_W      = 4;

  if (!rd_latency_legal(RAM_RD_LATENCY)) begin : g_bad_latency
    $fatal(1, "tdpram_fifo_ctrl: RAM_RD_LATENCY must be 1 or 2");
  end

  logic [ADDR_WIDTH-1:0]     wr_ptr_q, wr_ptr_d;
  logic [ADDR_WIDTH-1:0]     rd_ptr_q, rd_ptr_d;
  logic [RCW-1:0]            ram_cnt_q, ram_cnt_d;
  logic [CNT_W-1:0]          count_q, count_d;
  logic [RAM_RD_LATENCY-1:0] vpipe_q, vpipe_d;

  logic                      full;
  logic                      push;
  logic                      pop;
  logic                      issue;
  logic [OCC_W-1:0]          inflight;
  logic [OCC_W-1:0]          occ;
  logic [OCC_W-1:0]          occ_limit;
  logic                      skid_valid;
  logic [DATA_WIDTH-1:0]     skid_data;
  logic [SKID_CW-1:0]        skid_cnt;

  assign full = (ram_cnt_q == RCW'(DEPTH));

  // Handshakes, read issue decision and next-state for pointers/counters.
  always_comb begin
    push      = NRST_I & WR_VALID_I & ~full;
    pop       = NRST_I & skid_valid & RD_READY_I;
    inflight  = OCC_W'($countones(vpipe_q));
    occ       = inflight + OCC_W'(skid_cnt);
    // A word popped this cycle frees a skid slot for a new read.
    occ_limit = OCC_W'(RAM_RD_LATENCY + 1) + OCC_W'(pop);
    issue     = NRST_I & (ram_cnt_q != '0) & (occ < occ_limit);

    wr_ptr_d  = wr_ptr_q + ADDR_WIDTH'(push);
    rd_ptr_d  = rd_ptr_q + ADDR_WIDTH'(issue);
    ram_cnt_d = ram_cnt_q + RCW'(push) - RCW'(issue);
    count_d   = count_q + CNT_W'(push) - CNT_W'(pop);

    vpipe_d    = '0;
    vpipe_d[0] = issue;
    for (int i = 1; i < RAM_RD_LATENCY; i++) begin
      vpipe_d[i] = vpipe_q[i-1];
    end
  end

  // Pointer, occupancy and valid-pipe registers; RAM contents are untouched
  // by reset.
  always_ff @(posedge CLK_I) begin
    if (!NRST_I) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      ram_cnt_q <= '0;
      count_q   <= '0;
      vpipe_q   <= '0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      ram_cnt_q <= ram_cnt_d;
      count_q   <= count_d;
      vpipe_q   <= vpipe_d;
    end
  end

  // The tail of the valid pipe marks the cycle RAM_DOUTB_I carries the word.
  fifo_skid_buffer #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (SKID_DEPTH)
  ) u_skid (
    .clk     (CLK_I),
    .rst_n   (NRST_I),
    .push_i  (vpipe_q[RAM_RD_LATENCY-1]),
    .data_i  (RAM_DOUTB_I),
    .pop_i   (pop),
    .data_o  (skid_data),
    .valid_o (skid_valid),
    .count_o (skid_cnt)
  );

  assign WR_READY_O  = ~full;
  assign RD_DATA_O   = skid_data;
  assign RD_VALID_O  = skid_valid;
  assign RAM_WENA_O  = push;
  assign RAM_ADDRA_O = wr_ptr_q;
  assign RAM_DINA_O  = WR_DATA_I;
  assign RAM_WENB_O  = 1'b0;
  assign RAM_ADDRB_O = rd_ptr_q;
  assign COUNT_O     = count_q;
  assign FULL_O      = full;
  assign EMPTY_O     = (count_q == '0);
  assign AFULL_O     = (32'(ram_cnt_q) >= AFULL_THRESH);

endmodule
